// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: snapshots a flattened register-file bus in one cycle and
// streams it out one register per handshake, optionally only words changed since the last dump.
module regfile_dump_reader #(
   parameter int NUM_REGS   = 32,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_WIDTH  = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           changed_only,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] full_register_file,
   input  logic                           out_ready,
   output logic                           out_valid,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic [IDX_WIDTH-1:0]           out_index,
   output logic                           busy,
   output logic                           done
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SCAN = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [IDX_WIDTH-1:0]  idx_r;
   logic [IDX_WIDTH-1:0]  idx_s;
   logic                  mode_r;
   logic [DATA_WIDTH-1:0] snap_r [NUM_REGS];
   logic [DATA_WIDTH-1:0] prev_r [NUM_REGS];
   logic                  load_s;
   logic                  commit_s;
   logic                  emit_s;

   // Next-state, index advance and combinational outputs from registered state.
   always_comb begin
      state_s   = state_r;
      idx_s     = idx_r;
      load_s    = 1'b0;
      commit_s  = 1'b0;
      emit_s    = 1'b0;
      out_valid = 1'b0;
      out_data  = {DATA_WIDTH{1'b0}};
      out_index = {IDX_WIDTH{1'b0}};
      busy      = 1'b0;
      done      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               load_s  = 1'b1;
               idx_s   = {IDX_WIDTH{1'b0}};
               state_s = ST_SCAN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SCAN: begin
            busy      = 1'b1;
            emit_s    = !mode_r || (snap_r[idx_r] != prev_r[idx_r]);
            out_valid = emit_s;
            out_data  = snap_r[idx_r];
            out_index = idx_r;
            // A skipped register advances unconditionally; an emitted one waits for the transfer.
            if (!emit_s || out_ready) begin
               if (idx_r == LAST_IDX) begin
                  commit_s = 1'b1;
                  idx_s    = {IDX_WIDTH{1'b0}};
                  state_s  = ST_DONE;
               end else begin
                  idx_s = idx_r + IDX_WIDTH'(1);
               end
            end else begin
               idx_s = idx_r;
            end
         end
         ST_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Control state: FSM state, scan index and latched dump mode.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         idx_r   <= {IDX_WIDTH{1'b0}};
         mode_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         if (load_s) begin
            mode_r <= changed_only;
         end
      end
   end

   // Snapshot captured on an accepted start; prev only takes it once a dump completes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            snap_r[i] <= {DATA_WIDTH{1'b0}};
            prev_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         if (load_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               snap_r[i] <= full_register_file[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         if (commit_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               prev_r[i] <= snap_r[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: each dump's expected word list is
// derived from a register/previous-snapshot model and compared with what is transferred.
module tb_regfile_dump_reader;

   localparam int NR = 32;
   localparam int DW = 32;
   localparam int IW = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              changed_only = 1'b0;
   logic              out_ready = 1'b0;
   logic [NR*DW-1:0]  full_register_file;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic [IW-1:0]     out_index;
   logic              busy;
   logic              done;

   logic [DW-1:0]     bus    [NR];
   logic [DW-1:0]     prev_m [NR];
   int                n_checks = 0;
   int                n_errors = 0;

   regfile_dump_reader #(.NUM_REGS(NR), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .changed_only       (changed_only),
      .full_register_file (full_register_file),
      .out_ready          (out_ready),
      .out_valid          (out_valid),
      .out_data           (out_data),
      .out_index          (out_index),
      .busy               (busy),
      .done               (done)
   );

   always #5 clk = ~clk;

   always_comb begin
      full_register_file = '0;
      for (int i = 0; i < NR; i++) full_register_file[i*DW +: DW] = bus[i];
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One dump: start is driven now, accepted at the next edge; cycle 1 is the first scan cycle.
   task automatic run_dump(input bit co, input bit rnd_ready, input bit hold,
                           input bit iso, input int rst_at);
      logic [DW-1:0] snap_m [NR];
      int            exp_idx[$];
      logic [DW-1:0] exp_dat[$];
      int            got_idx[$];
      logic [DW-1:0] got_dat[$];
      bit            pv = 1'b0;
      bit            pr = 1'b0;
      logic [DW-1:0] pd = '0;
      logic [IW-1:0] p_idx = '0;
      int            done_cyc = -1;

      for (int i = 0; i < NR; i++) begin
         snap_m[i] = bus[i];
         if (!co || bus[i] != prev_m[i]) begin
            exp_idx.push_back(i);
            exp_dat.push_back(bus[i]);
         end
      end
      start        = 1'b1;
      changed_only = co;
      out_ready    = 1'b1;

      for (int cyc = 1; cyc <= 600; cyc++) begin
         @(posedge clk);
         #1;
         if (!hold) start = 1'b0;
         changed_only = 1'($urandom_range(0, 1));
         if (pv && !pr) begin
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_data", out_data, pd);
            check_eq("hold_index", 32'(out_index), 32'(p_idx));
         end
         if (done) begin
            check_eq("valid_in_done", 32'(out_valid), 32'd0);
            done_cyc = cyc;
            break;
         end
         check_eq("busy_scan", 32'(busy), 32'd1);
         if (iso && cyc == 10) bus[5] = 32'hDEAD_BEEF;
         if (rst_at >= 0 && out_valid && int'(out_index) == rst_at) begin
            rst = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b1;
            check_eq("rst_valid", 32'(out_valid), 32'd0);
            check_eq("rst_done", 32'(done), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            for (int i = 0; i < NR; i++) prev_m[i] = '0;
            start     = 1'b0;
            out_ready = 1'b0;
            return;
         end
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid && out_ready) begin
            got_idx.push_back(int'(out_index));
            got_dat.push_back(out_data);
         end
         pv    = out_valid;
         pr    = out_ready;
         pd    = out_data;
         p_idx = out_index;
      end

      check_eq("done_seen", 32'(done_cyc > 0), 32'd1);
      if (done_cyc > 0 && !rnd_ready) check_eq("done_cycle", 32'(done_cyc), 32'd33);
      check_eq("n_words", 32'(got_idx.size()), 32'(exp_idx.size()));
      for (int k = 0; k < exp_idx.size() && k < got_idx.size(); k++) begin
         check_eq("word_index", 32'(got_idx[k]), 32'(exp_idx[k]));
         check_eq("word_data", got_dat[k], exp_dat[k]);
      end
      @(posedge clk);
      #1;
      check_eq("busy_after", 32'(busy), 32'd0);
      check_eq("valid_after", 32'(out_valid), 32'd0);
      for (int i = 0; i < NR; i++) prev_m[i] = snap_m[i];
      if (iso) bus[5] = snap_m[5];
      out_ready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin
         bus[i]    = 32'h1000_0000 + 32'(i);
         prev_m[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", out_data, 32'd0);
      check_eq("rst_out_index", 32'(out_index), 32'd0);
      check_eq("rst_out_busy", 32'(busy), 32'd0);
      check_eq("rst_out_done", 32'(done), 32'd0);
      rst = 1'b1;

      run_dump(1'b0, 1'b0, 1'b0, 1'b0, -1);   // full mode, always ready
      run_dump(1'b0, 1'b1, 1'b0, 1'b0, -1);   // backpressure
      run_dump(1'b0, 1'b0, 1'b0, 1'b1, -1);   // bus change mid-dump
      bus[3]  = 32'hAAAA_0003;
      bus[31] = 32'hAAAA_001F;
      run_dump(1'b1, 1'b0, 1'b0, 1'b0, -1);   // two changed words
      run_dump(1'b1, 1'b0, 1'b0, 1'b0, -1);   // no change: empty dump
      for (int i = 0; i < NR; i++) bus[i] = 32'h1000_0000 + 32'(i);
      run_dump(1'b0, 1'b0, 1'b1, 1'b0, -1);   // start held through the dump
      run_dump(1'b0, 1'b0, 1'b0, 1'b0, -1);   // the dump that held start launches
      run_dump(1'b0, 1'b0, 1'b0, 1'b0, 10);   // reset at index 10
      run_dump(1'b1, 1'b0, 1'b0, 1'b0, -1);   // prev cleared: all 32 words

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NR; i++) begin
            if ($urandom_range(0, 3) == 0) bus[i] = $urandom;
         end
         run_dump(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
